// File: rtl/fixed_mul_seq_if.sv
// Strobe/valid handshake bundle shared by the fixed-point multiplier and its callers.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 32
`endif

interface fixed_mul_seq_if #(
    parameter int W = `FIXED_WIDTH
);
    logic         strobe;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         valid;
    logic [W-1:0] q;

    modport master (output strobe, a, b, input busy, valid, q);
    modport slave  (input strobe, a, b, output busy, valid, q);
endinterface

// File: rtl/fixed_mul_seq.sv
// Sequential signed fixed-point multiplier: radix-2^STEP shift-add on magnitudes,
// fixed latency of K = ceil(W/STEP) edges, one operation in flight.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 32
`endif
`ifndef FIXED_FRAC_WIDTH
`define FIXED_FRAC_WIDTH 16
`endif

module fixed_mul_seq #(
    parameter int STEP     = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    fixed_mul_seq_if.slave bus
);
    localparam int W  = `FIXED_WIDTH;
    localparam int F  = `FIXED_FRAC_WIDTH;
    localparam int K  = (W + STEP - 1) / STEP;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0]  K_CNT   = CW'(K);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [W-1:0]   ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] PMAX    = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [2*W-1:0] NMAG    = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

    typedef enum logic [0:0] {ST_READY = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t         state_r, state_s;
    logic [2*W-1:0] acc_r, acc_s;
    logic [2*W-1:0] mcand_r, mcand_s;
    logic [W-1:0]   mplier_r, mplier_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic           sign_r, sign_s;
    logic [W-1:0]   q_r, q_s;
    logic           valid_r, valid_s;
    logic           busy_r, busy_s;
    logic [2*W-1:0] digit_s, acc_sum_s, m_s;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        if (v[W-1]) mag = ~v + ONE_W;
        else        mag = v;
    endfunction

    // Zero magnitude negates to zero, so no negative zero can appear.
    function automatic logic [W-1:0] apply_sign(input logic [2*W-1:0] m, input logic s);
        logic [W-1:0] r;
        r = s ? (~m[W-1:0] + ONE_W) : m[W-1:0];
        if (SATURATE && !s && (m > PMAX))     apply_sign = {1'b0, {(W-1){1'b1}}};
        else if (SATURATE && s && (m > NMAG)) apply_sign = {1'b1, {(W-1){1'b0}}};
        else                                  apply_sign = r;
    endfunction

    // Partial product: the multiplicand is pre-shifted, so no iteration index is needed.
    assign digit_s   = {{(2*W-STEP){1'b0}}, mplier_r[STEP-1:0]};
    assign acc_sum_s = acc_r + mcand_r * digit_s;
    assign m_s       = acc_sum_s >> F;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_r <= ST_READY;
        else         state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_READY: begin
                if (bus.strobe) state_s = ST_BUSY;
                else            state_s = ST_READY;
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ONE) state_s = ST_READY;
                else                  state_s = ST_BUSY;
            end
            default: state_s = ST_READY;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        acc_s    = acc_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        cnt_s    = cnt_r;
        sign_s   = sign_r;
        q_s      = q_r;
        valid_s  = 1'b0;
        busy_s   = busy_r;
        case (state_r)
            ST_READY: begin
                if (bus.strobe) begin
                    sign_s   = bus.a[W-1] ^ bus.b[W-1];
                    mcand_s  = {{W{1'b0}}, mag(bus.a)};
                    mplier_s = mag(bus.b);
                    acc_s    = '0;
                    cnt_s    = K_CNT;
                    busy_s   = 1'b1;
                end else begin
                    busy_s   = 1'b0;
                end
            end
            ST_BUSY: begin
                acc_s    = acc_sum_s;
                mcand_s  = mcand_r << STEP;
                mplier_s = mplier_r >> STEP;
                cnt_s    = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    q_s     = apply_sign(m_s, sign_r);
                    valid_s = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    busy_s  = 1'b1;
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            sign_r   <= 1'b0;
            q_r      <= '0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            acc_r    <= acc_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            cnt_r    <= cnt_s;
            sign_r   <= sign_s;
            q_r      <= q_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
        end
    end

    assign bus.busy  = busy_r;
    assign bus.valid = valid_r;
    assign bus.q     = q_r;
endmodule

// File: tb/tb_fixed_mul_seq.sv
// Self-checking bench for fixed_mul_seq: directed handshake/range scenarios on the
// STEP=8 units plus a randomized sweep of STEP 1/5/32 against an arithmetic model.
module tb_fixed_mul_seq;
    logic        clk    = 1'b0;
    logic        resetn = 1'b1;
    logic        strobe = 1'b0;
    logic [31:0] a      = 32'h0;
    logic [31:0] b      = 32'h0;
    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int vcount [5] = '{0, 0, 0, 0, 0};
    int vcyc   [5] = '{0, 0, 0, 0, 0};
    logic [31:0] vq [5];
    int kk     [5] = '{4, 4, 32, 7, 1};
    bit satv   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0]  v_all;
    logic [4:0]  b_all;
    logic [31:0] q_all [5];

    fixed_mul_seq_if #(.W(32)) if0 ();
    fixed_mul_seq_if #(.W(32)) if1 ();
    fixed_mul_seq_if #(.W(32)) if2 ();
    fixed_mul_seq_if #(.W(32)) if3 ();
    fixed_mul_seq_if #(.W(32)) if4 ();

    assign if0.strobe = strobe; assign if0.a = a; assign if0.b = b;
    assign if1.strobe = strobe; assign if1.a = a; assign if1.b = b;
    assign if2.strobe = strobe; assign if2.a = a; assign if2.b = b;
    assign if3.strobe = strobe; assign if3.a = a; assign if3.b = b;
    assign if4.strobe = strobe; assign if4.a = a; assign if4.b = b;

    fixed_mul_seq #(.STEP(8),  .SATURATE(1'b1)) dut8   (.clk(clk), .resetn(resetn), .bus(if0.slave));
    fixed_mul_seq #(.STEP(8),  .SATURATE(1'b0)) dut8w  (.clk(clk), .resetn(resetn), .bus(if1.slave));
    fixed_mul_seq #(.STEP(1),  .SATURATE(1'b1)) dut1   (.clk(clk), .resetn(resetn), .bus(if2.slave));
    fixed_mul_seq #(.STEP(5),  .SATURATE(1'b1)) dut5   (.clk(clk), .resetn(resetn), .bus(if3.slave));
    fixed_mul_seq #(.STEP(32), .SATURATE(1'b1)) dut32  (.clk(clk), .resetn(resetn), .bus(if4.slave));

    assign v_all = {if4.valid, if3.valid, if2.valid, if1.valid, if0.valid};
    assign b_all = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
    assign q_all[0] = if0.q;
    assign q_all[1] = if1.q;
    assign q_all[2] = if2.q;
    assign q_all[3] = if3.q;
    assign q_all[4] = if4.q;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse of every unit mid-cycle
    always @(negedge clk) begin
        for (int d = 0; d < 5; d++) begin
            if (v_all[d]) begin
                vcount[d] <= vcount[d] + 1;
                vq[d]     <= q_all[d];
                vcyc[d]   <= cyc;
            end
        end
    end

    // Arithmetic reference: exact product of magnitudes, truncate, sign, clamp
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input bit sat);
        longint sx;
        longint sy;
        longint m;
        longint r;
        bit     neg;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        neg = x[31] ^ y[31];
        if (sx < 0) sx = -sx;
        if (sy < 0) sy = -sy;
        m = (sx * sy) / 65536;
        if (sat && !neg && m > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (sat && neg && m > 64'sh8000_0000)  return 32'h8000_0000;
        if (m == 0) return 32'h0;
        r = neg ? -m : m;
        return r[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] q8, output logic [31:0] qw);
        bit ok;
        ok = 1'b0;
        strobe = 1'b1; a = x; b = y;
        step();
        strobe = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (v_all[0]) begin
                ok = 1'b1;
                break;
            end
        end
        q8 = q_all[0];
        qw = q_all[1];
        checks++;
        if (!ok || !v_all[1]) begin
            errors++;
            $display("FAIL run_op_valid a=%h b=%h got valid=%b/%b want 1/1 within 12 cycles", x, y, v_all[0], v_all[1]);
        end
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        step();
        step();
        for (int d = 0; d < 5; d++) begin
            checks++;
            if (v_all[d] !== 1'b0 || b_all[d] !== 1'b0 || q_all[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state unit=%0d got valid=%b busy=%b q=%h want 0 0 00000000", d, v_all[d], b_all[d], q_all[d]);
            end
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_latency();
        strobe = 1'b1; a = 32'h0001_8000; b = 32'h0002_0000;
        step();
        strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (v_all[0] !== 1'b0 || b_all[0] !== 1'b1) begin
                errors++;
                $display("FAIL latency_busy edge=N+%0d got valid=%b busy=%b want 0 1", i, v_all[0], b_all[0]);
            end
            if (i < 3) step();
        end
        step();
        checks++;
        if (v_all[0] !== 1'b1 || b_all[0] !== 1'b0 || q_all[0] !== 32'h0003_0000) begin
            errors++;
            $display("FAIL latency_done got valid=%b busy=%b q=%h want 1 0 00030000", v_all[0], b_all[0], q_all[0]);
        end
        step();
        checks++;
        if (v_all[0] !== 1'b0 || q_all[0] !== 32'h0003_0000) begin
            errors++;
            $display("FAIL latency_hold got valid=%b q=%h want 0 00030000", v_all[0], q_all[0]);
        end
    endtask

    task automatic test_range();
        logic [31:0] ta [9] = '{32'h0001_8000, 32'hFFFE_8000, 32'hFFFF_0000, 32'h0100_0000, 32'h8000_0000,
                                32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFF00_0000};
        logic [31:0] tb [9] = '{32'h0002_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0100_0000, 32'h0001_0000,
                                32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h0100_0000};
        logic [31:0] es [9] = '{32'h0003_0000, 32'hFFFD_0000, 32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] ew [9] = '{32'h0003_0000, 32'hFFFD_0000, 32'h0001_0000, 32'h0000_0000, 32'h8000_0000,
                                32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        logic [31:0] q8;
        logic [31:0] qw;
        for (int i = 0; i < 9; i++) begin
            run_op(ta[i], tb[i], q8, qw);
            checks++;
            if (q8 !== es[i]) begin
                errors++;
                $display("FAIL range_sat case=%0d got %h want %h", i, q8, es[i]);
            end
            checks++;
            if (qw !== ew[i]) begin
                errors++;
                $display("FAIL range_wrap case=%0d got %h want %h", i, qw, ew[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int snap;
        snap = vcount[0];
        strobe = 1'b1; a = 32'h0003_0000; b = 32'h0002_0000;
        step();
        strobe = 1'b0;
        step();
        strobe = 1'b1; a = 32'h0007_0000; b = 32'h0005_0000;
        step();
        strobe = 1'b0;
        step();
        checks++;
        if (v_all[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early got valid=%b want 0", v_all[0]);
        end
        step();
        checks++;
        if (v_all[0] !== 1'b1 || q_all[0] !== 32'h0006_0000) begin
            errors++;
            $display("FAIL b2b_first got valid=%b q=%h want 1 00060000", v_all[0], q_all[0]);
        end
        strobe = 1'b1; a = 32'hFFFC_0000; b = 32'h0000_8000;
        step();
        strobe = 1'b0;
        checks++;
        if (b_all[0] !== 1'b1 || v_all[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept_in_valid got busy=%b valid=%b want 1 0", b_all[0], v_all[0]);
        end
        repeat (4) step();
        checks++;
        if (v_all[0] !== 1'b1 || q_all[0] !== 32'hFFFE_0000 || vcount[0] != snap + 1) begin
            errors++;
            $display("FAIL b2b_second got valid=%b q=%h pulses=%0d want 1 fffe0000 %0d", v_all[0], q_all[0], vcount[0] - snap, 1);
        end
    endtask

    task automatic test_strobe_held();
        int snap;
        int t0;
        step();
        snap = vcount[0];
        t0 = cyc;
        strobe = 1'b1; a = 32'h0005_0000; b = 32'hFFFF_8000;
        repeat (10) step();
        strobe = 1'b0;
        repeat (6) step();
        checks++;
        if (vcount[0] != snap + 2 || vcyc[0] != t0 + 10 || vq[0] !== 32'hFFFD_8000) begin
            errors++;
            $display("FAIL strobe_held got pulses=%0d last_cycle=+%0d q=%h want 2 +10 fffd8000", vcount[0] - snap, vcyc[0] - t0, vq[0]);
        end
    endtask

    task automatic test_reset_abort();
        int snap;
        logic [31:0] q8;
        logic [31:0] qw;
        repeat (40) step();
        snap = vcount[0];
        strobe = 1'b1; a = 32'h0003_0000; b = 32'h0003_0000;
        step();
        strobe = 1'b0;
        step();
        step();
        resetn = 1'b0;
        #1;
        checks++;
        if (v_all[0] !== 1'b0 || b_all[0] !== 1'b0 || q_all[0] !== 32'h0) begin
            errors++;
            $display("FAIL abort_clear got valid=%b busy=%b q=%h want 0 0 00000000", v_all[0], b_all[0], q_all[0]);
        end
        step();
        step();
        resetn = 1'b1;
        repeat (8) step();
        checks++;
        if (vcount[0] != snap) begin
            errors++;
            $display("FAIL abort_no_valid got pulses=%0d want 0", vcount[0] - snap);
        end
        run_op(32'h0002_0000, 32'h0002_0000, q8, qw);
        checks++;
        if (q8 !== 32'h0004_0000) begin
            errors++;
            $display("FAIL abort_recover got %h want 00040000", q8);
        end
    endtask

    task automatic test_random_sweep();
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp_q;
        int snap [5];
        int t0;
        repeat (40) step();
        for (int n = 0; n < 40; n++) begin
            x = 32'($signed($urandom) >>> $urandom_range(0, 31));
            y = 32'($signed($urandom) >>> $urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) x = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0) y = 32'h0;
            for (int d = 0; d < 5; d++) snap[d] = vcount[d];
            t0 = cyc;
            strobe = 1'b1; a = x; b = y;
            step();
            strobe = 1'b0;
            repeat (36) step();
            for (int d = 0; d < 5; d++) begin
                exp_q = ref_mul(x, y, satv[d]);
                checks++;
                if (vcount[d] != snap[d] + 1 || vq[d] !== exp_q || vcyc[d] != t0 + 1 + kk[d]) begin
                    errors++;
                    $display("FAIL random unit=%0d a=%h b=%h got q=%h pulses=%0d lat=%0d want q=%h pulses=1 lat=%0d",
                             d, x, y, vq[d], vcount[d] - snap[d], vcyc[d] - t0 - 1, exp_q, kk[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_range();
        test_back_to_back();
        test_strobe_held();
        test_reset_abort();
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
